muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit placed between the register file read ports and its write port.
- Consumes the two source operand values read for an M-type instruction.
- Computes the result over XLEN cycles using shift-add multiply or restoring divide.
- Returns one write-back beat (rd, data, write enable) that drives the register file write port; busy stalls the core while the operation runs.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit for M-type instructions.
// It sits between the register file read ports and the write port. It takes
// XLEN iterations per operation: shift-add for multiply, restoring division
// for divide. It produces a single write-back beat when the result is ready.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous reset, active-low (0 = reset)
//   start    - request a new operation; sampled only while idle
//   op       - 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   rs1_val  - operand A (multiplicand / dividend)
//   rs2_val  - operand B (multiplier / divisor)
//   rd_in    - destination register index
//   busy     - high from the accepting edge through the DONE cycle
//   wb_we    - one-cycle write strobe (suppressed when rd = 0)
//   wb_rd    - destination index, held until the next DONE or reset
//   wb_data  - result, held until the next DONE or reset
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          op_q;
  logic [4:0]          rd_q;
  // a_q holds the multiplicand. For a divide it holds the dividend, which
  // shifts left while quotient bits enter at the bottom.
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     b_q;
  logic [XLEN-1:0]     rem_q;
  logic [2*XLEN-1:0]   acc_q;

  logic                is_div;
  logic                last_iter;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   acc_next;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       rem_diff;
  logic                div_ge;
  logic [XLEN-1:0]     rem_next;
  logic [XLEN-1:0]     quo_next;

  function automatic logic [XLEN-1:0] select_result(
    input logic [1:0]        sel,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    case (sel)
      2'b00:   return prod[XLEN-1:0];
      2'b01:   return prod[2*XLEN-1:XLEN];
      2'b10:   return quo;
      default: return rem;
    endcase
  endfunction

  assign is_div    = op_q[1];
  assign last_iter = (cnt == CNT_W'(XLEN - 1));

  always_comb begin
    // The multiplier bit for this iteration is selected by cnt (LSB first).
    // The accumulator shifts right, so the upper half always lines up with
    // the multiplicand. The extra carry bit becomes the new MSB.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (b_q[cnt] ? a_q : '0)};
    acc_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: bring down the next dividend bit (MSB first).
    rem_sh   = {rem_q, a_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    div_ge   = (rem_sh >= {1'b0, b_q});
    rem_next = div_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_next = {a_q[XLEN-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            rd_q  <= rd_in;
            a_q   <= rs1_val;
            b_q   <= rs2_val;
            acc_q <= '0;
            rem_q <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            // A zero divisor has a fixed answer, so the unit skips the iterations.
            if (op[1] && (rs2_val == '0)) begin
              state   <= DONE;
              wb_we   <= (rd_in != 5'd0);
              wb_rd   <= rd_in;
              wb_data <= op[0] ? rs1_val : '1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem_q <= rem_next;
            a_q   <= quo_next;
          end else begin
            acc_q <= acc_next;
          end
          // The result is taken from the next-state values, so the output
          // register already holds it during the DONE cycle.
          if (last_iter) begin
            state   <= DONE;
            wb_we   <= (rd_q != 5'd0);
            wb_rd   <= rd_q;
            wb_data <= select_result(op_q, acc_next, quo_next, rem_next);
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          wb_we <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          wb_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit. Directed cases come first. Randomized operations
// follow. Every result is checked against plain arithmetic.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_i;
  logic            busy;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  int n_chk;
  int n_err;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op_i),
    .rs1_val (rs1),
    .rs2_val (rs2),
    .rd_in   (rd_i),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference results from plain arithmetic.
  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (op)
      2'd0:    return p[XLEN-1:0];
      2'd1:    return p[2*XLEN-1:XLEN];
      2'd2:    return (b == 0) ? {XLEN{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one operation and watch a fixed window of cycles. Cycle 1 is the
  // cycle right after the accepting edge. inj1/inj2 pulse start with junk
  // operands during those cycles. abort_cyc drops rst for one edge.
  task automatic run_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [4:0] rd,
                        input int inj1, input int inj2, input int abort_cyc);
    int busy_cnt, pulses, pulse_cyc, win, exp_lat;
    logic [XLEN-1:0] expv, got_data;
    logic [4:0] got_rd;
    expv      = model(op, a, b);
    exp_lat   = (op[1] && b == 0) ? 1 : XLEN + 1;
    win       = (abort_cyc > 0) ? abort_cyc + 4 : exp_lat + 3;
    busy_cnt  = 0;
    pulses    = 0;
    pulse_cyc = 0;
    got_data  = '0;
    got_rd    = '0;
    @(negedge clk);
    start = 1'b1; op_i = op; rs1 = a; rs2 = b; rd_i = rd;
    @(posedge clk);
    #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; rd_i = 5'($urandom); op_i = 2'($urandom);
    for (int k = 1; k <= win; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      rst   = 1'b1;
      if (busy) busy_cnt++;
      if (wb_we) begin
        pulses++;
        if (pulse_cyc == 0) pulse_cyc = k;
        got_data = wb_data;
        got_rd   = wb_rd;
      end
      if (k == inj1 || k == inj2) begin
        start = 1'b1; op_i = 2'($urandom); rs1 = $urandom; rs2 = $urandom; rd_i = 5'($urandom);
      end
      if (k == abort_cyc) rst = 1'b0;
    end
    start = 1'b0;
    rst   = 1'b1;
    if (abort_cyc > 0) begin
      chk({name, " abort_pulses"}, 64'(pulses), 64'd0);
      chk({name, " abort_busy"}, 64'(busy), 64'd0);
      chk({name, " abort_data"}, 64'(wb_data), 64'd0);
      chk({name, " abort_rd"}, 64'(wb_rd), 64'd0);
    end else begin
      chk({name, " pulses"}, 64'(pulses), (rd != 0) ? 64'd1 : 64'd0);
      chk({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
      chk({name, " busy_end"}, 64'(busy), 64'd0);
      if (rd != 0) begin
        chk({name, " latency"}, 64'(pulse_cyc), 64'(exp_lat));
        chk({name, " wb_rd"}, 64'(got_rd), 64'(rd));
        chk({name, " wb_data"}, 64'(got_data), 64'(expv));
        chk({name, " data_hold"}, 64'(wb_data), 64'(expv));
      end
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic [XLEN-1:0] ra, rb;
    n_chk = 0;
    n_err = 0;
    rst = 1'b0; start = 1'b0; op_i = '0; rs1 = '0; rs2 = '0; rd_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset wb_we", 64'(wb_we), 64'd0);
    chk("reset wb_rd", 64'(wb_rd), 64'd0);
    chk("reset wb_data", 64'(wb_data), 64'd0);

    run_op("mul7x6", 2'd0, 32'd7, 32'd6, 5'd5, 0, 0, 0);
    chk("mul7x6 const", 64'(wb_data), 64'h2A);
    run_op("mulhu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 0, 0);
    chk("mulhu_max const", 64'(wb_data), 64'hFFFF_FFFE);
    run_op("mul_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 0, 0);
    chk("mul_max const", 64'(wb_data), 64'h1);
    run_op("divu100_7", 2'd2, 32'd100, 32'd7, 5'd9, 0, 0, 0);
    chk("divu100_7 const", 64'(wb_data), 64'hE);
    run_op("remu100_7", 2'd3, 32'd100, 32'd7, 5'd9, 0, 0, 0);
    chk("remu100_7 const", 64'(wb_data), 64'h2);
    run_op("divu5_9", 2'd2, 32'd5, 32'd9, 5'd1, 0, 0, 0);
    chk("divu5_9 const", 64'(wb_data), 64'h0);
    run_op("remu5_9", 2'd3, 32'd5, 32'd9, 5'd1, 0, 0, 0);
    chk("remu5_9 const", 64'(wb_data), 64'h5);
    run_op("divu_by0", 2'd2, 32'h1234, 32'd0, 5'd7, 0, 0, 0);
    chk("divu_by0 const", 64'(wb_data), 64'hFFFF_FFFF);
    run_op("remu_by0", 2'd3, 32'h1234, 32'd0, 5'd7, 0, 0, 0);
    chk("remu_by0 const", 64'(wb_data), 64'h1234);
    run_op("start_busy", 2'd0, 32'h0001_2345, 32'h0000_0ABC, 5'd12, 5, 20, 0);
    run_op("abort_div", 2'd2, 32'hDEAD_BEEF, 32'd3, 5'd4, 0, 0, 10);
    run_op("rd0_mul", 2'd0, 32'd11, 32'd13, 5'd0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0 ? $urandom : 32'($urandom_range(1, 1000)));
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 5'($urandom_range(1, 31)), 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
